// File: rtl/div_8bit_pkg.sv
// div_8bit_pkg -- shared definitions for the 8-bit sequential divider.
//   div_state_t   : FSM states IDLE / CALC / DONE
//   DIV_WIDTH     : operand width (8)
//   DIV_ITERS     : number of CALC iterations (one quotient bit each)
//   DIV_ZERO_QUOT : quotient reported for a zero divisor
//   neg_if()      : conditional two's-complement negate (signed build only)
package div_8bit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_WIDTH = 8;
    localparam int DIV_ITERS = 8;
    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = 8'hFF;

    function automatic logic [DIV_WIDTH-1:0] neg_if(input logic [DIV_WIDTH-1:0] v,
                                                    input logic en);
        return en ? (~v + DIV_WIDTH'(1)) : v;
    endfunction

endpackage

// File: rtl/sub_8bit.sv
// sub_8bit -- 8-bit subtractor with borrow-out.
//   a   : minuend
//   b   : subtrahend
//   d   : a - b (mod 256)
//   b_o : borrow out, 1 when b > a
module sub_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] d,
    output logic       b_o
);

    assign {b_o, d} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/div_8bit.sv
// div_8bit -- 8-bit restoring divider, one quotient bit per clock.
//   clk, rst         : clock, synchronous active-high reset
//   start            : request, accepted in IDLE or DONE
//   dividend/divisor : operands, sampled on the acceptance edge
//   signed_op        : two's-complement divide (only when DIV_SIGNED_EN is defined)
//   busy             : high while iterating
//   done             : one-cycle pulse, results valid
//   quotient/remainder : registered results, held until the next acceptance
//   div_zero         : last operation had a zero divisor
// Build option: define DIV_SIGNED_EN to add signed_op and the sign fixup logic.
module div_8bit
    import div_8bit_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
`ifdef DIV_SIGNED_EN
    input  logic       signed_op,
`endif
    input  logic [7:0] dividend,
    input  logic [7:0] divisor,
    output logic       busy,
    output logic       done,
    output logic [7:0] quotient,
    output logic [7:0] remainder,
    output logic       div_zero
);

    localparam logic [3:0] LAST_ITER = 4'(DIV_ITERS - 1);

    div_state_t           r_state;
    logic [3:0]           r_cnt;
    logic [DIV_WIDTH-1:0] r_part;   // partial remainder
    logic [DIV_WIDTH-1:0] r_qsh;    // dividend bits shift out MSB-first, quotient bits shift in
    logic [DIV_WIDTH-1:0] r_dvs;
    logic                 r_busy;
    logic                 r_done;
    logic [DIV_WIDTH-1:0] r_quot;
    logic [DIV_WIDTH-1:0] r_rem;
    logic                 r_dz;

    logic [DIV_WIDTH:0]   w_shift;
    logic [DIV_WIDTH-1:0] w_diff;
    logic                 w_bo;
    logic                 w_take;
    logic [DIV_WIDTH-1:0] w_part_nx;
    logic [DIV_WIDTH-1:0] w_quot_nx;
    logic [DIV_WIDTH-1:0] w_quot_fin;
    logic [DIV_WIDTH-1:0] w_rem_fin;
    logic [DIV_WIDTH-1:0] w_dvd_mag;
    logic [DIV_WIDTH-1:0] w_dvs_mag;
    logic                 w_dvs_zero;

    assign w_shift = {r_part, r_qsh[DIV_WIDTH-1]};

    sub_8bit u_sub (
        .a   (w_shift[DIV_WIDTH-1:0]),
        .b   (r_dvs),
        .d   (w_diff),
        .b_o (w_bo)
    );

    // A set bit 8 means the shifted value is >= 256 > divisor, so the
    // subtraction must be taken regardless of the 8-bit borrow.
    assign w_take    = w_shift[DIV_WIDTH] | ~w_bo;
    assign w_part_nx = w_take ? w_diff : w_shift[DIV_WIDTH-1:0];
    assign w_quot_nx = {r_qsh[DIV_WIDTH-2:0], w_take};
    assign w_dvs_zero = (divisor == '0);

`ifdef DIV_SIGNED_EN
    logic r_neg_q;
    logic r_neg_r;

    // Iterate on magnitudes; 8'h80 maps to 128, which fits unsigned.
    assign w_dvd_mag  = neg_if(dividend, signed_op & dividend[7]);
    assign w_dvs_mag  = neg_if(divisor,  signed_op & divisor[7]);
    assign w_quot_fin = neg_if(w_quot_nx, r_neg_q);
    assign w_rem_fin  = neg_if(w_part_nx, r_neg_r);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (start && (r_state == IDLE || r_state == DONE)) begin
            r_neg_q <= signed_op & (dividend[7] ^ divisor[7]);
            r_neg_r <= signed_op & dividend[7];
        end
    end
`else
    assign w_dvd_mag  = dividend;
    assign w_dvs_mag  = divisor;
    assign w_quot_fin = w_quot_nx;
    assign w_rem_fin  = w_part_nx;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_part  <= '0;
            r_qsh   <= '0;
            r_dvs   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_dz    <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state <= CALC;
                        r_cnt   <= '0;
                        r_part  <= '0;
                        r_dvs   <= w_dvs_mag;
                        // Zero divisor keeps the raw dividend for the remainder.
                        r_qsh   <= w_dvs_zero ? dividend : w_dvd_mag;
                        r_dz    <= 1'b0;
                        r_busy  <= ~w_dvs_zero;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                CALC: begin
                    if (r_dvs == '0) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_quot  <= DIV_ZERO_QUOT;
                        r_rem   <= r_qsh;
                        r_dz    <= 1'b1;
                    end else begin
                        r_part <= w_part_nx;
                        r_qsh  <= w_quot_nx;
                        r_cnt  <= r_cnt + 4'd1;
                        if (r_cnt == LAST_ITER) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_quot  <= w_quot_fin;
                            r_rem   <= w_rem_fin;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign quotient  = r_quot;
    assign remainder = r_rem;
    assign div_zero  = r_dz;

endmodule

// File: tb/tb_div_8bit.sv
// tb_div_8bit -- directed self-checking bench for div_8bit.
// Define DIV_SIGNED_EN on both files to also cover the signed build.
module tb_div_8bit;
    import div_8bit_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] dividend = '0;
    logic [7:0] divisor = '0;
`ifdef DIV_SIGNED_EN
    logic       signed_op = 1'b0;
`endif
    logic       busy, done, div_zero;
    logic [7:0] quotient, remainder;

    int n_tot = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    div_8bit dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
`ifdef DIV_SIGNED_EN
        .signed_op (signed_op),
`endif
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge: present operands and pass the acceptance edge.
    task automatic accept(input logic [7:0] a, input logic [7:0] b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
    endtask

    // After the acceptance edge: count edges (acceptance edge = 1) until done
    // is seen, and busy cycles. Optionally pulse a stray start 9/3 at inj.
    task automatic wait_done(input int inj, output int lat, output int bcnt, output logic ok);
        lat = 1; bcnt = 0; ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (i == inj) begin
                start = 1'b1; dividend = 8'd9; divisor = 8'd3;
            end else begin
                start = 1'b0;
            end
            if (busy) bcnt++;
            if (done) begin ok = 1'b1; break; end
            @(posedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] eq, input logic [7:0] er, input logic edz,
                          input int elat, input int ebusy);
        int lat, bcnt;
        logic ok;
        @(negedge clk);
        accept(a, b);
        wait_done(-1, lat, bcnt, ok);
        chk({tag, "_done_seen"}, ok, 1'b1);
        chk({tag, "_lat"}, lat, elat);
        chk({tag, "_busy_cyc"}, bcnt, ebusy);
        chk({tag, "_q"}, quotient, eq);
        chk({tag, "_r"}, remainder, er);
        chk({tag, "_dz"}, div_zero, edz);
        @(negedge clk);
        chk({tag, "_done_pulse"}, done, 1'b0);
        chk({tag, "_q_hold"}, quotient, eq);
    endtask

    initial begin
        int lat, bcnt;
        logic ok;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_q", quotient, 8'h00);
        chk("rst_r", remainder, 8'h00);
        chk("rst_dz", div_zero, 1'b0);
        chk("rst_state", dut.r_state, IDLE);

        run_op("d100_7",  8'd100, 8'd7,   8'd14,  8'd2,   1'b0, 9, 8);
        run_op("d255_1",  8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 9, 8);
        run_op("d3_10",   8'd3,   8'd10,  8'd0,   8'd3,   1'b0, 9, 8);
        run_op("d200_200",8'd200, 8'd200, 8'd1,   8'd0,   1'b0, 9, 8);
        run_op("d255_128",8'd255, 8'd128, 8'd1,   8'd127, 1'b0, 9, 8);
        run_op("d5_0",    8'd5,   8'd0,   8'hFF,  8'd5,   1'b1, 2, 0);
        // div_zero must clear on the next acceptance
        run_op("d17_4",   8'd17,  8'd4,   8'd4,   8'd1,   1'b0, 9, 8);

        // stray start during CALC is ignored
        @(negedge clk);
        accept(8'd100, 8'd7);
        wait_done(4, lat, bcnt, ok);
        chk("ign_done_seen", ok, 1'b1);
        chk("ign_lat", lat, 9);
        chk("ign_q", quotient, 8'd14);
        chk("ign_r", remainder, 8'd2);

        // start held during done: back-to-back acceptance
        accept(8'd50, 8'd5);
        wait_done(-1, lat, bcnt, ok);
        chk("b2b_done_seen", ok, 1'b1);
        chk("b2b_lat", lat, 9);
        chk("b2b_q", quotient, 8'd10);
        chk("b2b_r", remainder, 8'd0);

        // reset mid-CALC
        @(negedge clk);
        accept(8'd100, 8'd7);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_done", done, 1'b0);
        chk("mrst_q", quotient, 8'h00);
        chk("mrst_r", remainder, 8'h00);
        chk("mrst_dz", div_zero, 1'b0);
        chk("mrst_state", dut.r_state, IDLE);
        chk("mrst_cnt", dut.r_cnt, 4'd0);
        run_op("d50_6", 8'd50, 8'd6, 8'd8, 8'd2, 1'b0, 9, 8);

        // start together with rst is ignored
        @(negedge clk);
        rst = 1'b1; start = 1'b1; dividend = 8'd9; divisor = 8'd3;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rststart_busy", busy, 1'b0);
        chk("rststart_state", dut.r_state, IDLE);

`ifdef DIV_SIGNED_EN
        signed_op = 1'b1;
        run_op("s_m7_2",   8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, 9, 8);
        run_op("s_7_m2",   8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0, 9, 8);
        run_op("s_m128_m1",8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 9, 8);
        run_op("s_m5_0",   8'hFB, 8'h00, 8'hFF, 8'hFB, 1'b1, 2, 0);
        signed_op = 1'b0;
        run_op("u_128_255",8'h80, 8'hFF, 8'h00, 8'h80, 1'b0, 9, 8);
`endif

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule

// File: doc/div_8bit.md
DIV_8BIT -- requirements
Module: div_8bit

Interface
REQ-001 clk  input  1  single clock; all state changes on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 start  input  1  request; accepted only in IDLE or DONE.
REQ-004 dividend  input  8  numerator, sampled at acceptance edge.
REQ-005 divisor  input  8  denominator, sampled at acceptance edge.
REQ-006 signed_op  input  1  1 = two's-complement divide; port exists only with DIV_SIGNED_EN.
REQ-007 busy  output  1  high while iterating.
REQ-008 done  output  1  one-cycle pulse, results valid.
REQ-009 quotient  output  8  registered quotient, held until next acceptance.
REQ-010 remainder  output  8  registered remainder, held until next acceptance.
REQ-011 div_zero  output  1  registered; divisor was zero for the last operation.

Function
REQ-012 The FSM SHALL have states IDLE, CALC and DONE; the reset state is IDLE.
REQ-013 Acceptance: start=1 in IDLE or DONE latches operands, clears div_zero, enters CALC with iteration count 0; busy rises the cycle after.
REQ-014 start in CALC SHALL be ignored, with no effect on state or operands.
REQ-015 Algorithm: unsigned restoring division, MSB first, one quotient bit per CALC cycle, exactly 8 CALC cycles.
REQ-016 Per iteration: shifted = {partial[7:0], next dividend bit}; the subtractor computes shifted[7:0] minus divisor; take = shifted[8] OR NOT borrow-out; if take, partial = difference and quotient bit = 1, else partial = shifted[7:0] and quotient bit = 0.
REQ-017 done SHALL be high in the cycle after the 8th iteration edge, i.e. on the 9th edge after acceptance; CALC then moves to DONE, busy drops the same edge, and done lasts exactly one cycle.
REQ-018 DONE SHALL return to IDLE next edge unless start=1, which is accepted back-to-back.
REQ-019 Divisor zero: skip CALC and go to DONE on the next edge with quotient=8'hFF, remainder=dividend, div_zero=1.
REQ-020 quotient and remainder SHALL update only on the edge entering DONE and remain stable otherwise.

Reset
REQ-021 rst SHALL force IDLE, busy=0, done=0, div_zero=0, quotient=8'h00, remainder=8'h00 and iteration count 0, including mid-CALC, discarding the operation.
REQ-022 start asserted together with rst SHALL be ignored.

Configuration
REQ-023 Macro DIV_SIGNED_EN defined: signed_op=1 divides operand magnitudes and applies sign fixup on the DONE-entry edge; quotient is negative iff operand signs differ; remainder takes the dividend's sign; latency is unchanged.
REQ-024 With DIV_SIGNED_EN, 8'h80 / 8'hFF SHALL give quotient=8'h80, remainder=8'h00, no flag; divisor zero behaves as REQ-019.
REQ-025 Without DIV_SIGNED_EN, the signed_op port and all sign logic SHALL be absent and the block is unsigned only.

Structure
REQ-026 A shared package SHALL hold the FSM state enum (IDLE, CALC, DONE), DIV_WIDTH=8, the iteration count constant 8 and the zero-divide quotient constant 8'hFF.
REQ-027 The per-iteration subtraction SHALL instantiate the existing sub_8bit (a = shifted[7:0], b = divisor, outputs d and b_o); there are no other sub-modules.

Verification
REQ-028 100/7: done exactly 9 edges after acceptance, quotient=14, remainder=2, div_zero=0; busy high for 8 cycles.
REQ-029 255/1 gives 255 rem 0; 3/10 gives 0 rem 3; 200/200 gives 1 rem 0; 255/128 gives 1 rem 127 (exercises shifted[8]).
REQ-030 5/0: done on the 2nd edge after acceptance, quotient=8'hFF, remainder=5, div_zero=1, busy never high.
REQ-031 start with 9/3 at iteration 4 of 100/7: ignored, result 14 rem 2; start held at done gives back-to-back acceptance.
REQ-032 rst at iteration 5: next cycle all outputs are zero and state is IDLE; a new 50/6 gives 8 rem 2.
REQ-033 With DIV_SIGNED_EN: -7/2 gives 8'hFD rem 8'hFF; 7/-2 gives 8'hFD rem 1; -128/-1 gives 8'h80 rem 0.
